siso_shift_register: RTL and testbench
======================================

// Module: siso_shift_register
// PURPOSE
//   Serial-in serial-out shift register: delays a 1-bit serial stream by DEPTH clock cycles.
//   Used as a fixed bit-delay line or serializer tail in sequential datapaths.
//   Single clock domain. One bit enters and one bit leaves on every rising clock edge.
// PARAMETERS
//   DEPTH      4     number of register stages (delay in clock cycles); legal range 1..64
//   RST_VAL    1'b0  value loaded into every stage on reset
// PORTS
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous reset, active-high
//   serial_in   in   1  serial data input, sampled on each rising edge of clk
//   serial_out  out  1  serial data output; equals the last stage (stage DEPTH-1)
// BEHAVIOUR
//   - Storage: internal vector q[DEPTH-1:0]. q[0] is the input stage; q[DEPTH-1] drives serial_out.
//   - Reset:
//       - rst=1 immediately (no clock needed) forces every q[i]=RST_VAL and serial_out=RST_VAL.
//       - Reset is held for as long as rst=1; clock edges are ignored during reset.
//   - Shift: on each rising clk edge with rst=0:
//       - q[0] <= serial_in;
//       - q[i] <= q[i-1] for i=1..DEPTH-1.
//   - Latency: a bit sampled at edge k appears on serial_out just after edge k+DEPTH-1,
//     i.e. DEPTH captures including its own. For DEPTH=1, serial_out follows serial_in delayed one edge.
//   - serial_out is a pure register output with no combinational path from serial_in.
//   - Reset release:
//       - The first edge with rst sampled low performs a normal shift.
//       - Deassertion coincident with an edge is a timing violation; the system guarantees
//         rst falls away from active clk edges.
//   - Reset mid-stream: all in-flight bits are discarded; the output returns to RST_VAL
//     until new data propagates through (DEPTH edges).
//   - No enable and no parallel load: the register shifts on every edge outside reset.
//   - X on serial_in propagates as X; no filtering.
// TESTING
//   1) Reset: rst=1 at t=0 with serial_in toggling -> serial_out=0 and all q=0 throughout;
//      asserting rst mid-stream clears serial_out within the same time step, without a clock edge.
//   2) Pattern 1,0,0,1 (DEPTH=4, one bit per edge after reset release) -> serial_out=0 for the
//      first 3 edges, then 1,0,0,1 on edges 4..7, then 0 once the input is held 0.
//   3) Single pulse: one-cycle 1 then zeros -> serial_out high for exactly one cycle, DEPTH edges later.
//   4) Stream 1,1,1,1,1,1,1,1 -> serial_out rises after edge 4 and stays 1 while input stays 1;
//      returns to 0 exactly 4 edges after the input drops.
//   5) Reset mid-operation: shift in 1,1,1, pulse rst for 5 ns between edges -> serial_out stays 0
//      for the next 4 edges (old 1s lost).
//   6) Parameter sweep DEPTH=1 and DEPTH=8 with random 64-bit stream
//      -> serial_out(k) == serial_in(k-DEPTH+1 captures) per a reference queue model.

Source files
------------

// File: rtl/siso_shift_register.sv
// Serial-in serial-out shift register.
// Delays a 1-bit serial stream by DEPTH clock cycles. Stage 0 captures
// serial_in and the last stage drives serial_out directly, so the output
// is a pure register output with no combinational path from the input.
module siso_shift_register #(
  parameter int   DEPTH   = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic serial_out
);

  logic [DEPTH-1:0] q_q;
  logic [DEPTH-1:0] q_d;

  // Next state: every stage takes its predecessor, stage 0 takes the input.
  always_comb begin
    q_d    = q_q;
    q_d[0] = serial_in;
    for (int i = 1; i < DEPTH; i++) begin
      q_d[i] = q_q[i-1];
    end
  end

  // Stage registers; reset clears the whole line at once, without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= {DEPTH{RST_VAL}};
    end else begin
      q_q <= q_d;
    end
  end

  assign serial_out = q_q[DEPTH-1];

endmodule

// File: tb/tb_siso_shift_register.sv
// Bench for siso_shift_register.
// Three instances (DEPTH 1, 4 and 8) share one clock, reset and input.
// Directed vectors run from a table; random streams are compared against a
// history-queue reference model.
module tb_siso_shift_register;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic out1, out4, out8;

  int tests  = 0;
  int failed = 0;

  // Every bit captured since the last reset, oldest first.
  logic hist[$];

  typedef struct {
    logic rst_first;
    logic din;
    logic exp4;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  siso_shift_register #(.DEPTH(1), .RST_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_out(out1));
  siso_shift_register #(.DEPTH(4), .RST_VAL(1'b0)) dut4 (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_out(out4));
  siso_shift_register #(.DEPTH(8), .RST_VAL(1'b0)) dut8 (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_out(out8));

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Output of a DEPTH-d line: the bit captured d edges ago, else the reset value.
  function automatic logic model(input int d);
    if (hist.size() < d) return 1'b0;
    return hist[hist.size() - d];
  endfunction

  // Called between edges: drive a bit, take one edge, check all instances.
  task automatic step(input logic b);
    serial_in = b;
    @(posedge clk);
    hist.push_back(b);
    #1;
    chk("model_d1", out1, model(1));
    chk("model_d4", out4, model(4));
    chk("model_d8", out8, model(8));
  endtask

  // Called at posedge+1: a 5 ns reset pulse that ends before the next edge.
  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk("async_clr_d1", out1, 1'b0);
    chk("async_clr_d4", out4, 1'b0);
    chk("async_clr_d8", out8, 1'b0);
    #4;
    rst = 1'b0;
    hist.delete();
  endtask

  function automatic void add(input logic r, input logic d, input logic e);
    vec_t v;
    v.rst_first = r;
    v.din       = d;
    v.exp4      = e;
    tbl.push_back(v);
  endfunction

  initial begin
    // Pattern 1,0,0,1 then zeros.
    add(1'b0, 1'b1, 1'b0); add(1'b0, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1); add(1'b0, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1); add(1'b0, 1'b0, 1'b0);
    // Single pulse.
    add(1'b1, 1'b1, 1'b0); add(1'b0, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1); add(1'b0, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0);
    // Eight ones then zeros.
    add(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) add(1'b0, 1'b1, (i >= 2) ? 1'b1 : 1'b0);
    add(1'b0, 1'b0, 1'b1); add(1'b0, 1'b0, 1'b1); add(1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0);
    // Shift in 1,1,1 then reset: the ones must never appear.
    add(1'b1, 1'b1, 1'b0); add(1'b0, 1'b1, 1'b0); add(1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0); add(1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0);

    // Reset from time zero with the input toggling: everything stays cleared.
    rst       = 1'b1;
    serial_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serial_in = ~serial_in;
      @(posedge clk);
      #1;
      chk("rst_hold_d1", out1, 1'b0);
      chk("rst_hold_d4", out4, 1'b0);
      chk("rst_hold_d8", out8, 1'b0);
      tests++;
      if (dut8.q_q !== 8'h00) begin
        failed++;
        $display("FAIL rst_hold_q8: got %h, expected 00", dut8.q_q);
      end
    end
    #1;
    rst = 1'b0;
    hist.delete();

    // Directed table.
    foreach (tbl[i]) begin
      if (tbl[i].rst_first) pulse_rst();
      step(tbl[i].din);
      chk($sformatf("vec%0d_d4", i), out4, tbl[i].exp4);
    end

    // Random streams, each starting from a fresh reset; one reset lands mid-stream.
    for (int r = 0; r < 3; r++) begin
      pulse_rst();
      for (int k = 0; k < 72; k++) begin
        step(1'($urandom_range(0, 1)));
        if (r == 1 && k == 30) pulse_rst();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule
